capture_sequencer: RTL and testbench

Synchronous capture controller sitting between the ADC sample bus and the sample FIFO, ahead of the PIC PMP readout interface. It sequences one triggered acquisition: pre-trigger fill, level/edge trigger search with a sliding pre-trigger window, post-trigger fill, then grants FIFO readout by holding `fifo_rden` until the FIFO drains. All outputs are registered in the `clock` domain.

---
 rtl/capture_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_capture_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// capture_sequencer
// Sequences one triggered acquisition between the ADC sample bus and the
// sample FIFO: pre-trigger fill, trigger search with a sliding pre-trigger
// window, post-trigger fill, then a readout grant held until the FIFO drains.
// Every output is a flop in the clock domain.
module capture_sequencer #(
    parameter int DEPTH_W = 11,
    parameter int ADC_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic [ADC_W-1:0]   adc_data,
    input  logic [ADC_W-1:0]   trig_level,
    input  logic               trig_rising,
    input  logic [DEPTH_W-1:0] pre_count,
    input  logic [DEPTH_W-1:0] post_count,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    output logic               fifo_wrck,
    output logic               fifo_drop,
    output logic [ADC_W-1:0]   fifo_wdata,
    output logic               fifo_rden,
    output logic               busy,
    output logic               triggered,
    output logic               overflow,
    output logic [DEPTH_W-1:0] sample_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        WAIT = 3'd2,
        POST = 3'd3,
        READ = 3'd4
    } state_t;

    localparam logic [DEPTH_W-1:0] CNT_MAX = '1;
    localparam logic [DEPTH_W-1:0] CNT_ONE = DEPTH_W'(1);

    state_t             state_q, state_d;

    // acquisition settings captured at arm time
    logic [DEPTH_W-1:0] pre_q, pre_d;
    logic [DEPTH_W-1:0] post_q, post_d;
    logic [ADC_W-1:0]   lvl_q, lvl_d;
    logic               rise_q, rise_d;

    // previous sample for edge detection, and whether it belongs to WAIT
    logic [ADC_W-1:0]   prev_q;
    logic               prev_vld_q, prev_vld_d;

    logic               wrck_q, wrck_d;
    logic               drop_q, drop_d;
    logic [ADC_W-1:0]   wdata_q, wdata_d;
    logic               rden_q, rden_d;
    logic               busy_q, busy_d;
    logic               trig_q, trig_d;
    logic               ovf_q, ovf_d;
    logic [DEPTH_W-1:0] cnt_q, cnt_d;

    logic [DEPTH_W-1:0] cnt_inc;
    logic               edge_hit;
    logic               trig_hit;

    // Saturating increment of the per-phase write counter.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    // Edge detection against the latched level; the first WAIT cycle is
    // excluded because prev still holds a PRE-phase sample.
    always_comb begin
        if (rise_q) begin
            edge_hit = (prev_q < lvl_q) && (adc_data >= lvl_q);
        end else begin
            edge_hit = (prev_q >= lvl_q) && (adc_data < lvl_q);
        end
        trig_hit = prev_vld_q && edge_hit;
    end

    // Next-state and registered-output logic for the acquisition FSM.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        post_d     = post_q;
        lvl_d      = lvl_q;
        rise_d     = rise_q;
        wrck_d     = 1'b0;
        drop_d     = 1'b0;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        trig_d     = trig_q;
        prev_vld_d = (state_q == WAIT);

        if (abort) begin
            // abort beats arm and every phase; overflow and count are kept
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d = PRE;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        pre_d   = pre_count;
                        post_d  = (post_count == '0) ? CNT_ONE : post_count;
                        lvl_d   = trig_level;
                        rise_d  = trig_rising;
                    end
                end
                PRE: begin
                    if (cnt_q >= pre_q) begin
                        state_d = WAIT;
                    end else if (fifo_full) begin
                        ovf_d   = 1'b1;
                        state_d = READ;
                    end else begin
                        wrck_d  = 1'b1;
                        wdata_d = adc_data;
                        cnt_d   = cnt_inc;
                    end
                end
                WAIT: begin
                    if (trig_hit) begin
                        // trigger sample is post sample 1 and is kept
                        wrck_d  = 1'b1;
                        wdata_d = adc_data;
                        trig_d  = 1'b1;
                        cnt_d   = CNT_ONE;
                        state_d = POST;
                    end else if (pre_q != '0) begin
                        // slide the window: add newest, discard oldest
                        wrck_d  = 1'b1;
                        drop_d  = 1'b1;
                        wdata_d = adc_data;
                    end
                end
                POST: begin
                    if (cnt_q >= post_q) begin
                        state_d = READ;
                    end else if (fifo_full) begin
                        ovf_d   = 1'b1;
                        state_d = READ;
                    end else begin
                        wrck_d  = 1'b1;
                        wdata_d = adc_data;
                        cnt_d   = cnt_inc;
                    end
                end
                READ: begin
                    if (fifo_empty) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d == IDLE) begin
            trig_d = 1'b0;
        end
        rden_d = (state_d == READ);
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            post_q     <= '0;
            lvl_q      <= '0;
            rise_q     <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            wrck_q     <= 1'b0;
            drop_q     <= 1'b0;
            wdata_q    <= '0;
            rden_q     <= 1'b0;
            busy_q     <= 1'b0;
            trig_q     <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            post_q     <= post_d;
            lvl_q      <= lvl_d;
            rise_q     <= rise_d;
            prev_q     <= adc_data;
            prev_vld_q <= prev_vld_d;
            wrck_q     <= wrck_d;
            drop_q     <= drop_d;
            wdata_q    <= wdata_d;
            rden_q     <= rden_d;
            busy_q     <= busy_d;
            trig_q     <= trig_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fifo_wrck    = wrck_q;
    assign fifo_drop    = drop_q;
    assign fifo_wdata   = wdata_q;
    assign fifo_rden    = rden_q;
    assign busy         = busy_q;
    assign triggered    = trig_q;
    assign overflow     = ovf_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer. Each scenario is planned as an event timeline
// (arm edge, trigger edge, end of post fill, drain edge) from which the
// expected per-edge outputs are derived, then driven and compared.
module tb_capture_sequencer;
    localparam int DW   = 11;
    localparam int AW   = 8;
    localparam int MAXE = 256;

    logic          clock = 1'b0;
    logic          reset, arm, abort, trig_rising, fifo_full, fifo_empty;
    logic [AW-1:0] adc_data, trig_level;
    logic [DW-1:0] pre_count, post_count;
    logic          fifo_wrck, fifo_drop, fifo_rden, busy, triggered, overflow;
    logic [AW-1:0] fifo_wdata;
    logic [DW-1:0] sample_count;

    always #5 clock = ~clock;

    capture_sequencer #(.DEPTH_W(DW), .ADC_W(AW)) dut (
        .clock(clock), .reset(reset), .arm(arm), .abort(abort),
        .adc_data(adc_data), .trig_level(trig_level), .trig_rising(trig_rising),
        .pre_count(pre_count), .post_count(post_count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_wrck(fifo_wrck), .fifo_drop(fifo_drop), .fifo_wdata(fifo_wdata),
        .fifo_rden(fifo_rden), .busy(busy), .triggered(triggered),
        .overflow(overflow), .sample_count(sample_count)
    );

    int total = 0;
    int bad   = 0;

    // scenario description
    int  c_pre, c_post, c_lvl, c_full_rel, c_abort_ph, c_empty_gap;
    bit  c_rise, c_arm_post, c_rst_read;
    logic [AW-1:0] d [0:MAXE-1];

    // planned event edges (edge 0 = arm sampled)
    int t, w, P, F, R, E, A, Rs, n;
    logic [AW-1:0] last_wd;

    // {busy, wrck, drop, rden, triggered, overflow, wdata[7:0], count[10:0]}
    logic [24:0] expv [0:MAXE-1];
    logic [24:0] obs  [0:MAXE-1];

    function automatic bit hit(input int p, input int c);
        if (c_rise) return (p < c_lvl) && (c >= c_lvl);
        return (p >= c_lvl) && (c < c_lvl);
    endfunction

    function automatic int find_t();
        for (int j = c_pre + 3; j < MAXE - 60; j++)
            if (hit(int'(d[j-1]), int'(d[j]))) return j;
        return -1;
    endfunction

    task automatic cfg_default();
        c_full_rel = 0; c_abort_ph = 0; c_arm_post = 0; c_rst_read = 0;
        c_empty_gap = $urandom_range(0, 3);
    endtask

    task automatic rand_data_with_trigger();
        int x;
        for (int j = 0; j < MAXE; j++) d[j] = AW'($urandom_range(0, 255));
        x = c_pre + 4 + $urandom_range(0, 20);
        if (c_rise) begin d[x-1] = AW'(c_lvl - 1); d[x] = AW'(c_lvl); end
        else        begin d[x-1] = AW'(c_lvl);     d[x] = AW'(c_lvl - 1); end
    endtask

    // Build the expected per-edge output table from the event timeline.
    task automatic plan();
        int cnt, pc, wpost;
        bit b, wr, dr, rd, tg, ov, pov;
        logic [AW-1:0] wd;
        P  = (c_post == 0) ? 1 : c_post;
        w  = c_pre + 2;
        t  = find_t();
        F  = (c_full_rel > 0 && c_full_rel < P) ? t + c_full_rel : -1;
        R  = (F >= 0) ? F : t + P;
        E  = R + 1 + c_empty_gap;
        A  = (c_abort_ph == 1) ? t - 1 : (c_abort_ph == 2) ? t + 1 : -1;
        Rs = c_rst_read ? R + 1 : -1;
        n  = E + 3;
        if (A >= 0)  n = A + 3;
        if (Rs >= 0) n = Rs + 3;
        wpost = (F >= 0) ? F - t : P;
        wd = last_wd; pc = 0; pov = 1'b0;
        for (int j = 0; j < n; j++) begin
            b  = (j < E);
            wr = (j >= 1 && j <= c_pre) || (c_pre > 0 && j >= w && j < t) ||
                 (j >= t && j < t + wpost);
            dr = (c_pre > 0 && j >= w && j < t);
            rd = (j >= R && j < E);
            tg = (j >= t && j < E);
            ov = (F >= 0 && j >= F);
            if (j == 0)          cnt = 0;
            else if (j <= c_pre) cnt = j;
            else if (j < t)      cnt = c_pre;
            else                 cnt = (j - t + 1 < wpost) ? j - t + 1 : wpost;
            if (A >= 0 && j >= A) begin
                b = 0; wr = 0; dr = 0; rd = 0; tg = 0; cnt = pc; ov = pov;
            end
            if (wr) wd = d[j];
            if (Rs >= 0 && j >= Rs) begin
                b = 0; wr = 0; dr = 0; rd = 0; tg = 0; ov = 0; cnt = 0; wd = '0;
            end
            expv[j] = {b, wr, dr, rd, tg, ov, wd, DW'(cnt)};
            pc = cnt; pov = ov;
        end
        last_wd = wd;
    endtask

    // Apply the planned stimulus; settings are scrambled after arm so the
    // latched copies are what the DUT must use.
    task automatic drive_run();
        for (int j = 0; j < n; j++) begin
            adc_data   = d[j];
            arm        = (j == 0) || (c_arm_post && j > t && j <= R);
            abort      = (j == A);
            reset      = (j == Rs);
            fifo_full  = (j == F);
            fifo_empty = (j >= E);
            if (j == 0) begin
                pre_count = DW'(c_pre); post_count = DW'(c_post);
                trig_level = AW'(c_lvl); trig_rising = c_rise;
            end else begin
                pre_count  = DW'($urandom_range(0, 2047));
                post_count = DW'($urandom_range(0, 2047));
                trig_level = AW'($urandom_range(0, 255));
                trig_rising = 1'($urandom_range(0, 1));
            end
            @(posedge clock); #1;
            obs[j] = {busy, fifo_wrck, fifo_drop, fifo_rden, triggered, overflow,
                      fifo_wdata, sample_count};
        end
        arm = 0; abort = 0; reset = 0; fifo_full = 0; fifo_empty = 1;
    endtask

    task automatic test_reset();
        reset = 1; arm = 1; adc_data = 8'hA5;
        repeat (2) @(posedge clock);
        #1;
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset busy got %b want 0", busy); end
        total++; if (fifo_wrck !== 1'b0)    begin bad++; $display("FAIL reset wrck got %b want 0", fifo_wrck); end
        total++; if (fifo_drop !== 1'b0)    begin bad++; $display("FAIL reset drop got %b want 0", fifo_drop); end
        total++; if (fifo_rden !== 1'b0)    begin bad++; $display("FAIL reset rden got %b want 0", fifo_rden); end
        total++; if (triggered !== 1'b0)    begin bad++; $display("FAIL reset triggered got %b want 0", triggered); end
        total++; if (overflow !== 1'b0)     begin bad++; $display("FAIL reset overflow got %b want 0", overflow); end
        total++; if (fifo_wdata !== 8'h00)  begin bad++; $display("FAIL reset wdata got %h want 00", fifo_wdata); end
        total++; if (sample_count !== '0)   begin bad++; $display("FAIL reset count got %0d want 0", sample_count); end
        reset = 0; arm = 0;
        @(posedge clock); #1;
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL reset_idle busy got %b want 0", busy); end
        last_wd = '0;
    endtask

    task automatic test_ramp_rising();
        cfg_default();
        c_pre = 4; c_post = 8; c_rise = 1; c_lvl = 8'h80;
        for (int j = 0; j < MAXE; j++) d[j] = AW'((j * 16) & 255);
        plan(); drive_run();
        for (int j = 0; j < n; j++) begin
            total++;
            if (obs[j] !== expv[j]) begin bad++; $display("FAIL ramp edge %0d got %h want %h", j, obs[j], expv[j]); end
        end
    endtask

    task automatic test_falling_edge();
        int tj;
        cfg_default();
        c_pre = 2; c_post = 3; c_rise = 0; c_lvl = 8'h40;
        for (int j = 0; j < MAXE; j++) d[j] = (j < 10) ? 8'h90 : 8'h30;
        d[10] = 8'h50; d[11] = 8'h40; d[12] = 8'h40; d[13] = 8'h3F;
        plan(); drive_run();
        for (int j = 0; j < n; j++) begin
            total++;
            if (obs[j] !== expv[j]) begin bad++; $display("FAIL falling edge %0d got %h want %h", j, obs[j], expv[j]); end
        end
        tj = -1;
        for (int j = n - 1; j >= 0; j--) if (obs[j][20] && obs[j][23]) tj = j;
        total++;
        if (tj < 0 || obs[(tj < 0) ? 0 : tj][18:11] !== 8'h3F) begin
            bad++; $display("FAIL falling_trig_sample edge %0d got %h want 3f", tj, obs[(tj < 0) ? 0 : tj][18:11]);
        end
    endtask

    task automatic test_zero_counts();
        int nw, nd;
        cfg_default();
        c_pre = 0; c_post = 0; c_rise = 1; c_lvl = $urandom_range(1, 254);
        rand_data_with_trigger();
        plan(); drive_run();
        nw = 0; nd = 0;
        for (int j = 0; j < n; j++) begin
            total++;
            if (obs[j] !== expv[j]) begin bad++; $display("FAIL zero edge %0d got %h want %h", j, obs[j], expv[j]); end
            nw += int'(obs[j][23]); nd += int'(obs[j][22]);
        end
        total++; if (nw !== 1) begin bad++; $display("FAIL zero_writes got %0d want 1", nw); end
        total++; if (nd !== 0) begin bad++; $display("FAIL zero_drops got %0d want 0", nd); end
    endtask

    task automatic test_overflow();
        cfg_default();
        c_pre = 2; c_post = 10; c_rise = 1; c_lvl = $urandom_range(1, 254);
        c_full_rel = 2;
        rand_data_with_trigger();
        plan(); drive_run();
        for (int j = 0; j < n; j++) begin
            total++;
            if (obs[j] !== expv[j]) begin bad++; $display("FAIL overflow edge %0d got %h want %h", j, obs[j], expv[j]); end
        end
    endtask

    task automatic test_arm_abort_idle();
        arm = 1; abort = 1; adc_data = 8'h11;
        @(posedge clock); #1;
        arm = 0; abort = 0;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL arm_abort busy got %b want 0", busy); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL arm_abort overflow got %b want 1", overflow); end
        @(posedge clock); #1;
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL arm_abort_next busy got %b want 0", busy); end
        total++; if (fifo_wrck !== 1'b0) begin bad++; $display("FAIL arm_abort_next wrck got %b want 0", fifo_wrck); end
    endtask

    task automatic test_abort();
        for (int ph = 1; ph <= 2; ph++) begin
            cfg_default();
            c_pre = $urandom_range(1, 5); c_post = 6; c_rise = $urandom_range(0, 1);
            c_lvl = $urandom_range(1, 254); c_abort_ph = ph;
            rand_data_with_trigger();
            plan(); drive_run();
            for (int j = 0; j < n; j++) begin
                total++;
                if (obs[j] !== expv[j]) begin bad++; $display("FAIL abort%0d edge %0d got %h want %h", ph, j, obs[j], expv[j]); end
            end
        end
    endtask

    task automatic test_arm_in_post();
        cfg_default();
        c_pre = 3; c_post = 8; c_rise = 0; c_lvl = $urandom_range(1, 254);
        c_arm_post = 1;
        rand_data_with_trigger();
        plan(); drive_run();
        for (int j = 0; j < n; j++) begin
            total++;
            if (obs[j] !== expv[j]) begin bad++; $display("FAIL arm_in_post edge %0d got %h want %h", j, obs[j], expv[j]); end
        end
    endtask

    task automatic test_reset_in_read();
        cfg_default();
        c_pre = 2; c_post = 3; c_rise = 1; c_lvl = $urandom_range(1, 254);
        c_rst_read = 1; c_empty_gap = 2;
        rand_data_with_trigger();
        plan(); drive_run();
        for (int j = 0; j < n; j++) begin
            total++;
            if (obs[j] !== expv[j]) begin bad++; $display("FAIL reset_read edge %0d got %h want %h", j, obs[j], expv[j]); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            cfg_default();
            c_pre = $urandom_range(0, 10); c_post = $urandom_range(0, 10);
            c_rise = $urandom_range(0, 1); c_lvl = $urandom_range(1, 254);
            c_full_rel = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
            rand_data_with_trigger();
            plan(); drive_run();
            for (int j = 0; j < n; j++) begin
                total++;
                if (obs[j] !== expv[j]) begin bad++; $display("FAIL random%0d edge %0d got %h want %h", k, j, obs[j], expv[j]); end
            end
        end
    endtask

    initial begin
        reset = 1; arm = 0; abort = 0; fifo_full = 0; fifo_empty = 1;
        adc_data = '0; trig_level = '0; trig_rising = 0;
        pre_count = '0; post_count = '0; last_wd = '0;
        test_reset();
        test_ramp_rising();
        test_falling_edge();
        test_zero_counts();
        test_overflow();
        test_arm_abort_idle();
        test_random();
        test_abort();
        test_arm_in_post();
        test_reset_in_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
